// File: rtl/game_flow_ctrl.sv
// Game flow sequencer: menu/start/play/banner/game-over FSM with per-player score and HP.
// Optional GAME_PAUSE_EN macro adds the PAUSED state, toggled by the pause key.

module game_flow_player #(
    parameter int HP_W     = 3,
    parameter int SCORE_W  = 11,
    parameter int START_HP = 3
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic               load,
    input  logic               play,
    input  logic               kill_cr,
    input  logic               hit,
    output logic [SCORE_W-1:0] score,
    output logic [HP_W-1:0]    hp,
    output logic               alive_nxt
);
    logic [HP_W-1:0] hp_nxt;

    always_comb begin
        hp_nxt = hp;
        if (play && hit && (hp != '0))
            hp_nxt = hp - 1'b1;
    end

    // Liveness after this edge's hit, so the FSM can act on it at the same edge.
    assign alive_nxt = (hp_nxt != '0);

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            score <= '0;
            hp    <= '0;
        end else if (load) begin
            score <= '0;
            hp    <= HP_W'(START_HP);
        end else if (play) begin
            hp <= hp_nxt;
            if (kill_cr && (score != '1))
                score <= score + 1'b1;
        end
    end
endmodule

module game_flow_ctrl #(
    parameter int NUM_PLAYERS       = 2,
    parameter int START_HP          = 3,
    parameter int HP_W              = 3,
    parameter int ENEMIES_PER_LEVEL = 20,
    parameter int NUM_LEVELS        = 4,
    parameter int SCORE_W           = 11,
    parameter int DELAY_FRAMES      = 120,
    localparam int EN_W  = $clog2(ENEMIES_PER_LEVEL + 1),
    localparam int LVL_W = (NUM_LEVELS > 2) ? $clog2(NUM_LEVELS) : 1,
    localparam int CNT_W = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1
) (
    input  logic                           frame_clk,
    input  logic                           Reset,
    input  logic                           start,
    input  logic                           pause,
    input  logic [NUM_PLAYERS-1:0]         kill,
    input  logic [NUM_PLAYERS-1:0]         hit,
    output logic [2:0]                     state,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score,
    output logic [NUM_PLAYERS*HP_W-1:0]    hp,
    output logic [EN_W-1:0]                enemies_left,
    output logic [LVL_W-1:0]               level,
    output logic                           playing,
    output logic                           gameover
);
    typedef enum logic [2:0] {
        S_MENU        = 3'd0,
        S_START       = 3'd1,
        S_PLAYING     = 3'd2,
        S_PAUSED      = 3'd3,
        S_LEVEL_CLEAR = 3'd4,
        S_WON         = 3'd5,
        S_DEAD        = 3'd6,
        S_GAMEOVER    = 3'd7
    } state_t;

    state_t                                 state_q, state_nxt;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0]    score_arr;
    logic [NUM_PLAYERS-1:0][HP_W-1:0]       hp_arr;
    logic [NUM_PLAYERS-1:0]                 kill_cr, alive_nxt;
    logic [EN_W-1:0]                        en_q, en_play_nxt;
    logic [LVL_W-1:0]                       lvl_q;
    logic [CNT_W-1:0]                       cnt_q;
    logic                                   banner, expire, last_lvl, in_play, in_start;

    assign in_play  = (state_q == S_PLAYING);
    assign in_start = (state_q == S_START);
    assign banner   = (state_q == S_LEVEL_CLEAR) || (state_q == S_WON) || (state_q == S_DEAD);
    assign expire   = (cnt_q == CNT_W'(DELAY_FRAMES - 1));
    assign last_lvl = (lvl_q == LVL_W'(NUM_LEVELS - 1));

`ifndef GAME_PAUSE_EN
    logic pause_unused;
    assign pause_unused = pause;
`endif

    // Kills are credited in player-index order while enemies remain, so player 0 wins ties.
    always_comb begin
        en_play_nxt = en_q;
        kill_cr     = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (kill[i] && (hp_arr[i] != '0) && (en_play_nxt != '0)) begin
                kill_cr[i]  = 1'b1;
                en_play_nxt = en_play_nxt - 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pl
        game_flow_player #(
            .HP_W(HP_W), .SCORE_W(SCORE_W), .START_HP(START_HP)
        ) u_pl (
            .frame_clk(frame_clk),
            .Reset    (Reset),
            .load     (in_start),
            .play     (in_play),
            .kill_cr  (kill_cr[g]),
            .hit      (hit[g]),
            .score    (score_arr[g]),
            .hp       (hp_arr[g]),
            .alive_nxt(alive_nxt[g])
        );
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) state_q <= S_MENU;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_MENU:        if (start) state_nxt = S_START;
            S_START:       state_nxt = S_PLAYING;
            S_PLAYING: begin
                if (alive_nxt == '0)        state_nxt = S_DEAD;
                else if (en_play_nxt == '0) state_nxt = S_LEVEL_CLEAR;
`ifdef GAME_PAUSE_EN
                else if (pause)             state_nxt = S_PAUSED;
`endif
            end
`ifdef GAME_PAUSE_EN
            S_PAUSED:      if (pause) state_nxt = S_PLAYING;
`endif
            S_LEVEL_CLEAR: if (expire) state_nxt = last_lvl ? S_WON : S_PLAYING;
            S_WON,
            S_DEAD:        if (expire) state_nxt = S_GAMEOVER;
            S_GAMEOVER:    if (start) state_nxt = S_MENU;
            default:       state_nxt = S_MENU;
        endcase
    end

    always_comb begin
        state    = state_q;
        playing  = (state_q == S_PLAYING);
        gameover = (state_q == S_GAMEOVER);
    end

    // Banner counter restarts on every state change, so each banner lasts DELAY_FRAMES.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            en_q  <= '0;
            lvl_q <= '0;
            cnt_q <= '0;
        end else begin
            if (state_q != state_nxt) cnt_q <= '0;
            else if (banner)          cnt_q <= cnt_q + 1'b1;
            case (state_q)
                S_START: begin
                    en_q  <= EN_W'(ENEMIES_PER_LEVEL);
                    lvl_q <= '0;
                end
                S_PLAYING: en_q <= en_play_nxt;
                S_LEVEL_CLEAR: if (expire && !last_lvl) begin
                    en_q  <= EN_W'(ENEMIES_PER_LEVEL);
                    lvl_q <= lvl_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign score        = score_arr;
    assign hp           = hp_arr;
    assign enemies_left = en_q;
    assign level        = lvl_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed game scenarios then random play, all against a rule-level model.
module tb_game_flow_ctrl;
    localparam int NP = 2, SHP = 3, HW = 3, EPL = 20, NL = 4, SW = 11, DF = 4;
    localparam int EW = $clog2(EPL + 1);
    localparam int LW = 2;
    localparam int SMAX = (1 << SW) - 1;

    logic              frame_clk = 1'b0;
    logic              Reset = 1'b1, start = 1'b0, pause = 1'b0;
    logic [NP-1:0]     kill = '0, hit = '0;
    logic [2:0]        state;
    logic [NP*SW-1:0]  score;
    logic [NP*HW-1:0]  hp;
    logic [EW-1:0]     enemies_left;
    logic [LW-1:0]     level;
    logic              playing, gameover;

    int checks = 0, errors = 0;

    // model: game state in plain integers, named by state value
    int m_st, m_cnt, m_en, m_lvl;
    int m_score[NP];
    int m_hp[NP];

    game_flow_ctrl #(
        .NUM_PLAYERS(NP), .START_HP(SHP), .HP_W(HW), .ENEMIES_PER_LEVEL(EPL),
        .NUM_LEVELS(NL), .SCORE_W(SW), .DELAY_FRAMES(DF)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset), .start(start), .pause(pause),
        .kill(kill), .hit(hit), .state(state), .score(score), .hp(hp),
        .enemies_left(enemies_left), .level(level), .playing(playing), .gameover(gameover)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_step(input bit s, input bit p, input bit [NP-1:0] k,
                                       input bit [NP-1:0] h, input bit r);
        int left, alive;
        if (r) begin
            m_st = 0; m_cnt = 0; m_en = 0; m_lvl = 0;
            for (int i = 0; i < NP; i++) begin m_score[i] = 0; m_hp[i] = 0; end
            return;
        end
        case (m_st)
            0: if (s) m_st = 1;
            1: begin
                for (int i = 0; i < NP; i++) begin m_score[i] = 0; m_hp[i] = SHP; end
                m_en = EPL; m_lvl = 0; m_st = 2;
            end
            2: begin
                left = m_en;
                for (int i = 0; i < NP; i++)
                    if (k[i] && m_hp[i] > 0 && left > 0) begin
                        if (m_score[i] < SMAX) m_score[i]++;
                        left--;
                    end
                for (int i = 0; i < NP; i++)
                    if (h[i] && m_hp[i] > 0) m_hp[i]--;
                m_en = left;
                alive = 0;
                for (int i = 0; i < NP; i++) if (m_hp[i] > 0) alive++;
                if (alive == 0)      begin m_st = 6; m_cnt = 0; end
                else if (m_en == 0)  begin m_st = 4; m_cnt = 0; end
`ifdef GAME_PAUSE_EN
                else if (p)          m_st = 3;
`endif
            end
            3: if (p) m_st = 2;
            4, 5, 6: begin
                if (m_cnt == DF - 1) begin
                    m_cnt = 0;
                    if (m_st != 4)             m_st = 7;
                    else if (m_lvl == NL - 1)  m_st = 5;
                    else begin m_lvl++; m_en = EPL; m_st = 2; end
                end else m_cnt++;
            end
            7: if (s) m_st = 0;
            default: ;
        endcase
    endfunction

    task automatic compare_all();
        logic [NP*SW-1:0] es;
        logic [NP*HW-1:0] eh;
        es = '0; eh = '0;
        for (int i = 0; i < NP; i++) begin
            es[i*SW +: SW] = SW'(m_score[i]);
            eh[i*HW +: HW] = HW'(m_hp[i]);
        end
        chk("state", state, m_st);
        chk("score", score, es);
        chk("hp", hp, eh);
        chk("enemies_left", enemies_left, m_en);
        chk("level", level, m_lvl);
        chk("playing", playing, (m_st == 2));
        chk("gameover", gameover, (m_st == 7));
    endtask

    task automatic cyc(input bit s, input bit p, input bit [NP-1:0] k,
                       input bit [NP-1:0] h, input bit r);
        start = s; pause = p; kill = k; hit = h; Reset = r;
        @(posedge frame_clk);
        model_step(s, p, k, h, r);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 2'b00, 2'b00, 0);
    endtask

    initial begin
        m_st = 7; m_cnt = 0; m_en = 0; m_lvl = 0;
        for (int i = 0; i < NP; i++) begin m_score[i] = 1; m_hp[i] = 1; end
        cyc(0, 0, 2'b00, 2'b00, 1);
        cyc(1, 0, 2'b11, 2'b11, 1);
        chk("reset_state", state, 0);

        // start sequence
        cyc(1, 0, 2'b00, 2'b00, 0);
        chk("start_state", state, 1);
        idle(1);
        chk("play_hp", hp, {3'd3, 3'd3});
        chk("play_en", enemies_left, 20);

        // clear level 0 with single kills
        for (int i = 0; i < 20; i++) cyc(0, 0, 2'b01, 2'b00, 0);
        chk("lc_state", state, 4);
        chk("lc_score0", score[SW-1:0], 20);
        idle(3);
        chk("lc_hold", state, 4);
        idle(1);
        chk("lvl1_state", state, 2);
        chk("lvl1_level", level, 1);

        // simultaneous kill on last enemy
        for (int i = 0; i < 19; i++) cyc(0, 0, 2'b01, 2'b00, 0);
        cyc(0, 0, 2'b11, 2'b00, 0);
        chk("tie_score0", score[SW-1:0], 40);
        chk("tie_score1", score[2*SW-1:SW], 0);
        chk("tie_en", enemies_left, 0);
        idle(4);

        // both players die
        for (int i = 0; i < 3; i++) cyc(0, 0, 2'b00, 2'b11, 0);
        chk("dead_state", state, 6);
        idle(4);
        chk("go_state", state, 7);
        cyc(0, 0, 2'b00, 2'b11, 0);
        chk("go_hp", hp, 0);

        // final level: last kill and last hit at the same edge
        cyc(1, 0, 2'b00, 2'b00, 0);
        cyc(1, 0, 2'b00, 2'b00, 0);
        idle(1);
        for (int l = 0; l < NL - 1; l++) begin
            for (int i = 0; i < 10; i++) cyc(0, 0, 2'b11, 2'b00, 0);
            idle(4);
        end
        chk("final_lvl", level, 3);
        for (int i = 0; i < 2; i++) cyc(0, 0, 2'b00, 2'b11, 0);
        for (int i = 0; i < 9; i++) cyc(0, 0, 2'b11, 2'b00, 0);
        cyc(0, 0, 2'b01, 2'b00, 0);
        cyc(0, 0, 2'b01, 2'b11, 0);
        chk("final_dead", state, 6);
        cyc(0, 0, 2'b00, 2'b00, 1);
        chk("rst_dead_state", state, 0);
        chk("rst_dead_score", score, 0);

        // pause key
        cyc(1, 0, 2'b00, 2'b00, 0);
        idle(1);
        cyc(0, 1, 2'b00, 2'b00, 0);
        cyc(0, 0, 2'b01, 2'b00, 0);
`ifdef GAME_PAUSE_EN
        chk("paused_score", score[SW-1:0], 0);
        chk("paused_state", state, 3);
`else
        chk("nopause_score", score[SW-1:0], 1);
        chk("nopause_state", state, 2);
`endif
        cyc(0, 1, 2'b00, 2'b00, 0);
        chk("pause_back", state, 2);

        // random play
        for (int n = 0; n < 4000; n++) begin
            bit [NP-1:0] k, h;
            k = NP'($urandom_range(0, 3));
            h = '0;
            for (int i = 0; i < NP; i++) h[i] = ($urandom_range(0, 15) == 0);
            cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0), k, h,
                ($urandom_range(0, 499) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
